// File: rtl/serial_word_capture.sv
// Oversampling capture of a framed serial word stream into a first-word-fall-through FIFO.
// Flags short frames, long frames and FIFO overflow with single-cycle pulses.
module serial_word_capture #(
  parameter int WORD_BITS   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ser_en,
  input  logic                                 ser_clk,
  input  logic                                 ser_data,
  output logic [WORD_BITS-1:0]                 m_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic                                 err_short,
  output logic                                 err_long,
  output logic                                 ovf
);

  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(WORD_BITS + 1);
  localparam int PRW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] en_sync_q, clk_sync_q, dat_sync_q;
  logic                   clk_d_q;
  logic [PRW-1:0]         prime_q;
  logic                   en_s, clk_s, dat_s, edge_s, primed;

  assign en_s   = en_sync_q[SYNC_STAGES-1];
  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign dat_s  = dat_sync_q[SYNC_STAGES-1];
  assign edge_s = clk_s & ~clk_d_q;
  // Synchronizer outputs only reflect ser_en once every stage has been refilled after reset.
  assign primed = (prime_q == PRW'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      en_sync_q  <= '0;
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_d_q    <= 1'b0;
      prime_q    <= '0;
    end else begin
      en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], ser_en};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ser_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ser_data};
      clk_d_q    <= clk_s;
      if (!primed) prime_q <= prime_q + 1'b1;
    end
  end

  state_t               state_q, state_d;
  logic [WORD_BITS-2:0] sreg_q, sreg_d;
  logic [CW-1:0]        count_q, count_d, cnt_eff;
  logic [WORD_BITS-1:0] word_next;
  logic                 push_req, err_short_d, err_long_d;

  assign word_next = {sreg_q, dat_s};

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    count_d     = count_q;
    cnt_eff     = count_q;
    push_req    = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (primed && !en_s) state_d = IDLE;
      end
      IDLE: begin
        if (en_s) begin
          state_d = SHIFT;
          count_d = '0;
          if (edge_s) begin
            sreg_d  = word_next[WORD_BITS-2:0];
            count_d = CW'(1);
          end
        end
      end
      SHIFT: begin
        // A bit edge in the same cycle as the enable fall is counted before the fall is judged.
        if (edge_s) begin
          sreg_d  = word_next[WORD_BITS-2:0];
          cnt_eff = count_q + 1'b1;
        end
        if (edge_s && cnt_eff == CW'(WORD_BITS)) begin
          push_req = 1'b1;
          state_d  = DONE;
          count_d  = '0;
        end else if (!en_s) begin
          err_short_d = (cnt_eff != '0);
          state_d     = IDLE;
          count_d     = '0;
        end else begin
          count_d = cnt_eff;
        end
      end
      DONE: begin
        if (edge_s) err_long_d = 1'b1;
        if (!en_s) state_d = IDLE;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  logic [WORD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [LW-1:0]        level_q, level_d;
  logic [WORD_BITS-1:0] m_data_q, m_data_d;
  logic                 pop, full, do_push, ovf_d;
  logic                 err_short_q, err_long_q, ovf_q;

  assign rd_ptr_inc = rd_ptr_q + 1'b1;
  assign full       = (level_q == LW'(FIFO_DEPTH));
  assign pop        = m_valid && m_ready;
  assign do_push    = push_req && (!full || pop);
  assign ovf_d      = push_req && full && !pop;

  always_comb begin
    level_d = level_q;
    if (do_push && !pop) level_d = level_q + 1'b1;
    else if (!do_push && pop) level_d = level_q - 1'b1;
  end

  // Head register: next stored word after a pop, or the incoming word when the queue drains.
  always_comb begin
    m_data_d = m_data_q;
    if (pop) begin
      if (level_q > LW'(1)) m_data_d = mem_q[rd_ptr_inc];
      else if (do_push) m_data_d = word_next;
    end else if (level_q == '0 && do_push) begin
      m_data_d = word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= word_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOW;
      sreg_q      <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      m_data_q    <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      count_q     <= count_d;
      level_q     <= level_d;
      m_data_q    <= m_data_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      ovf_q       <= ovf_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_inc;
    end
  end

  assign m_valid    = (level_q != '0);
  assign m_data     = m_data_q;
  assign fifo_level = level_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_word_capture.sv
// Bench for serial_word_capture: directed frames plus randomized frames, checked every cycle
// against a frame/queue level model of the capture path.
module tb_serial_word_capture;
  localparam int WB = 32;
  localparam int SS = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst, ser_en, ser_clk, ser_data, m_ready;
  logic [WB-1:0] m_data;
  logic          m_valid, err_short, err_long, ovf;
  logic [2:0]    fifo_level;

  serial_word_capture #(.WORD_BITS(WB), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .ser_en(ser_en), .ser_clk(ser_clk), .ser_data(ser_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
    .err_short(err_short), .err_long(err_long), .ovf(ovf)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_short = 0, n_long = 0, n_ovf = 0;
  logic [WB-1:0] got_q[$];
  int rmode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_word(input string nm, input int idx, input logic [WB-1:0] exp);
    if (idx < got_q.size()) chk(nm, got_q[idx], exp);
    else begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no word, want %0h @%0t", nm, exp, $time);
    end
  endtask

  // Reference model: history queues of the raw inputs stand in for the synchronizer delay,
  // frames are tracked with booleans and a bit accumulator, the FIFO is a plain queue.
  bit            en_h[$], ck_h[$], dt_h[$];
  int            since;
  bit            armed, active, got;
  int            nbits;
  logic [WB-1:0] acc;
  logic [WB-1:0] mq[$];
  bit            e_short, e_long, e_ovf;

  initial begin
    forever begin : model
      bit en_s, ck_s, ck_d, d_s, edge_s, push, pop;
      logic [WB-1:0] pw;
      @(posedge clk);
      if (rst) begin
        en_h = {}; ck_h = {}; dt_h = {};
        for (int i = 0; i <= SS; i++) begin
          en_h.push_back(1'b0); ck_h.push_back(1'b0); dt_h.push_back(1'b0);
        end
        since = 0; armed = 0; active = 0; got = 0; nbits = 0; acc = '0;
        mq = {}; e_short = 0; e_long = 0; e_ovf = 0;
      end else begin
        en_s = en_h[SS-1]; ck_s = ck_h[SS-1]; ck_d = ck_h[SS]; d_s = dt_h[SS-1];
        edge_s = ck_s && !ck_d;
        push = 0; pw = '0;
        e_short = 0; e_long = 0; e_ovf = 0;
        pop = (mq.size() > 0) && m_ready;
        if (!armed) begin
          if (since >= SS && !en_s) armed = 1;
        end else if (!active) begin
          if (en_s) begin
            active = 1; got = 0; nbits = 0; acc = '0;
            if (edge_s) begin acc = WB'(d_s); nbits = 1; end
          end
        end else if (got) begin
          if (edge_s) e_long = 1;
          if (!en_s) active = 0;
        end else begin
          if (edge_s) begin
            acc = (acc << 1) | WB'(d_s);
            nbits++;
            if (nbits == WB) begin push = 1; pw = acc; got = 1; end
          end
          if (!got && !en_s) begin e_short = (nbits > 0); active = 0; end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
          if (mq.size() < FD) mq.push_back(pw);
          else e_ovf = 1;
        end
        if (since < SS) since++;
        en_h.push_front(ser_en);   void'(en_h.pop_back());
        ck_h.push_front(ser_clk);  void'(ck_h.pop_back());
        dt_h.push_front(ser_data); void'(dt_h.pop_back());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #5;
      chk("m_valid", m_valid, mq.size() > 0);
      chk("fifo_level", fifo_level, mq.size());
      if (mq.size() > 0) chk("m_data", m_data, mq[0]);
      chk("err_short", err_short, e_short);
      chk("err_long", err_long, e_long);
      chk("ovf", ovf, e_ovf);
      if (err_short) n_short++;
      if (err_long) n_long++;
      if (ovf) n_ovf++;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        $display("word popped %08h level %0d @%0t", m_data, fifo_level, $time);
      end
    end
  end

  // Consumer ready changes just after the rising edge so the compare sees the value the next edge uses.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0: m_ready = 1'b0;
        1: m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Every delay is a multiple of 4 ns after a falling clk edge, so serial changes never land on a rising edge.
  task automatic send(input logic [63:0] v, input int n, input int half);
    @(negedge clk);
    ser_en = 1'b1;
    #(half);
    for (int i = n - 1; i >= 0; i--) begin
      ser_data = v[i];
      #(half) ser_clk = 1'b1;
      #(half) ser_clk = 1'b0;
    end
    #(half) ser_en = 1'b0;
    ser_data = 1'b0;
    #(2 * half);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, want $finish @%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, s0, l0, o0, n, half;
    rst = 1'b1; ser_en = 1'b0; ser_clk = 1'b0; ser_data = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ser_clk = ~ser_clk; ser_en = ~ser_en; ser_data = ~ser_data;
    end
    @(negedge clk);
    ser_clk = 1'b0; ser_en = 1'b0; ser_data = 1'b0;
    chk("t1_valid", m_valid, 0);
    chk("t1_level", fifo_level, 0);
    chk("t1_data", m_data, 0);
    chk("t1_pulses", {err_short, err_long, ovf}, 0);
    rst = 1'b0;
    idle(5);

    rmode = 1; base = got_q.size();
    send(64'hA5C30F96, 32, 244);
    idle(10);
    chk("t2_count", got_q.size() - base, 1);
    expect_word("t2_word", base, 32'hA5C30F96);

    s0 = n_short; base = got_q.size();
    send(64'h1B2C3, 17, 244);
    idle(5);
    chk("t3_short", n_short - s0, 1);
    chk("t3_level", fifo_level, 0);
    send(64'h1, 32, 244);
    idle(10);
    expect_word("t3_word", base, 32'h00000001);

    rmode = 0; o0 = n_ovf; base = got_q.size();
    for (int k = 1; k <= 5; k++) send(64'(k), 32, 244);
    idle(5);
    chk("t4_level", fifo_level, 4);
    chk("t4_ovf", n_ovf - o0, 1);
    rmode = 1;
    idle(20);
    chk("t4_count", got_q.size() - base, 4);
    for (int k = 0; k < 4; k++) expect_word("t4_drain", base + k, WB'(k + 1));

    rmode = 0; l0 = n_long; base = got_q.size();
    send({31'h0, 32'h12345678, 1'b1}, 33, 244);
    idle(5);
    chk("t5_level", fifo_level, 1);
    chk("t5_long", n_long - l0, 1);
    rmode = 1;
    idle(10);
    expect_word("t5_word", base, 32'h12345678);

    base = got_q.size(); s0 = n_short; l0 = n_long;
    fork
      send(64'h0F0F0F0F, 32, 244);
      begin
        #(244 + 10 * 488);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(10);
    chk("t6_nowords", got_q.size() - base, 0);
    chk("t6_noerr", (n_short - s0) + (n_long - l0), 0);
    send(64'hDEADBEEF, 32, 244);
    idle(10);
    expect_word("t6_word", base, 32'hDEADBEEF);

    rmode = 2;
    for (int f = 0; f < 25; f++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 34)) : 32;
      half = 4 * int'($urandom_range(25, 50));
      if (f % 6 == 5) rmode = 0;
      else if (f % 6 == 0) rmode = 2;
      send({$urandom, $urandom}, n, half);
    end
    rmode = 1;
    idle(50);
    chk("final_level", fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
